expr_shared_scheduler: RTL and testbench
========================================

EXPR_SHARED_SCHEDULER -- requirements
Module: expr_shared_scheduler

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  operand set offered.
REQ-005: in_ready  output  1  block accepts an operand set.
REQ-006: X, Y, Z, P, Q, R, S, T  input  32 each  operands.
REQ-007: out_valid  output  1  result set available.
REQ-008: out_ready  input  1  consumer takes the result set.
REQ-009: output1..output6  output  32 each  results.
REQ-010: busy  output  1  high in COMPUTE.
REQ-011: step  output  4  current micro-step (0 outside COMPUTE).

Function
REQ-012: Results SHALL be: output1=X*Y+(Z+P); output2=(Z+P)*(Q-R); output3=Y+S+X+T; output4=(X*Y+Q)*(X+P); output5=(X*Y+P)-(R+(X+P)); output6=((X+P)+Y)*(Q-R).
REQ-013: All arithmetic SHALL be unsigned modulo 2^32, keeping the low 32 bits of every sum, difference and product.
REQ-014: The datapath SHALL contain exactly one 32x32 multiplier and one 32-bit add/sub unit; each unit performs at most one operation per cycle.
REQ-015: FSM states SHALL be IDLE, COMPUTE and DONE.
REQ-016: In IDLE, in_ready=1; when in_valid&&in_ready, all eight operands are latched and the FSM enters COMPUTE with step=0.
REQ-017: Latched operands SHALL be the only source for the computation; input changes after acceptance have no effect.
REQ-018: COMPUTE SHALL run steps 0..11, one per cycle, each result registered at the end of its step:
- step 0: m=X*Y; zp=Z+P
- step 1: qr=Q-R
- step 2: xp=X+P; output2=zp*qr
- step 3: output1=m+zp
- step 4: t4=m+Q
- step 5: t5=xp+Y; output4=t4*xp
- step 6: a=m+P; output6=t5*qr
- step 7: b=R+xp
- step 8: output5=a-b
- step 9: s=Y+S
- step 10: s=s+X
- step 11: output3=s+T; go to DONE
REQ-019: out_valid SHALL assert in the cycle after step 11, i.e. 13 cycles after the accept edge, and only in DONE.
REQ-020: In DONE, out_valid=1 and output1..6 SHALL hold stable until out_ready=1; that handshake returns the FSM to IDLE on the next edge.
REQ-021: in_ready SHALL be 0 in COMPUTE and DONE; in_valid in those states is ignored and nothing is queued.
REQ-022: in_ready SHALL NOT depend combinationally on out_ready; the minimum accept-to-accept interval is 14 cycles.
REQ-023: output1..6 are meaningful only while out_valid=1; outside DONE they may hold partial values.

Reset
REQ-024: On rst=1 at a clock edge, from any state including mid-COMPUTE or DONE, the FSM SHALL enter IDLE with out_valid=0, busy=0, step=0, and output1..6 and all temporaries cleared to 0.
REQ-025: in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-026: A result interrupted by reset SHALL never be presented.

Verification
REQ-027: Nominal: X=2 Y=3 Z=4 P=5 Q=10 R=7 S=1 T=1 -> out_valid 13 cycles after accept; output1=15, output2=27, output3=7, output4=112, output5=0xFFFFFFFD, output6=30.
REQ-028: Wrap: X=Y=0x00010000, Z=0xFFFFFFFF, P=1, Q=R=S=T=0 -> output1=0, output2=0, output3=0x00020000, output4=0, output5=0xFFFF0000, output6=0.
REQ-029: Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stay stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-030: Reset mid-operation: assert rst at step=6 -> next cycle IDLE, all outputs 0, out_valid=0; a fresh nominal run then gives the REQ-027 results.
REQ-031: Operand isolation: change X to 0xDEADBEEF one cycle after accept and hold in_valid=1 -> results unchanged from REQ-027, no second accept before IDLE.
REQ-032: Back-to-back: in_valid held high with out_ready=1 -> accepts exactly 14 cycles apart; step sequence 0..11 observed each time.

Source files
------------

// File: rtl/expr_shared_scheduler_if.sv
// Operand/result handshake bundle for expr_shared_scheduler; master = producer/consumer side, slave = scheduler.
// Carries the valid/ready pairs, the eight operands, the six results and the busy/step status.
interface expr_shared_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X, Y, Z, P, Q, R, S, T;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] output1, output2, output3, output4, output5, output6;
  logic        busy;
  logic [3:0]  step;

  modport master (
    output in_valid, X, Y, Z, P, Q, R, S, T, out_ready,
    input  in_ready, out_valid, output1, output2, output3, output4, output5, output6, busy, step
  );

  modport slave (
    input  in_valid, X, Y, Z, P, Q, R, S, T, out_ready,
    output in_ready, out_valid, output1, output2, output3, output4, output5, output6, busy, step
  );
endinterface

// File: rtl/expr_shared_scheduler.sv
// Six-expression evaluator on one shared multiplier and one add/sub unit; 12 compute steps, result handshake 13 cycles after accept.
// Backpressure: results held in DONE until out_ready; in_ready low from accept until the result is taken.
module expr_shared_scheduler (
  input logic                   clk,
  input logic                   rst,
  expr_shared_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic        accept;

  logic [31:0] x_q, y_q, z_q, p_q, q_q, r_q, s_q, t_q;
  logic [31:0] m_q, zp_q, qr_q, xp_q, t4_q, t5_q, a_q, b_q, sum_q;
  logic [31:0] o1_q, o2_q, o3_q, o4_q, o5_q, o6_q;

  logic [31:0] mul_a, mul_b, mul_r;
  logic [31:0] alu_a, alu_b, alu_r;
  logic        alu_sub;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = COMPUTE;
          step_d  = 4'd0;
        end
      end
      COMPUTE: begin
        if (step_q == 4'd11) begin
          state_d = DONE;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand steering for the two shared units; step 0 uses the defaults.
  always_comb begin
    mul_a   = x_q;
    mul_b   = y_q;
    alu_a   = z_q;
    alu_b   = p_q;
    alu_sub = 1'b0;
    case (step_q)
      4'd1:  begin alu_a = q_q;  alu_b = r_q; alu_sub = 1'b1; end
      4'd2:  begin mul_a = zp_q; mul_b = qr_q; alu_a = x_q; alu_b = p_q; end
      4'd3:  begin alu_a = m_q;  alu_b = zp_q; end
      4'd4:  begin alu_a = m_q;  alu_b = q_q; end
      4'd5:  begin mul_a = t4_q; mul_b = xp_q; alu_a = xp_q; alu_b = y_q; end
      4'd6:  begin mul_a = t5_q; mul_b = qr_q; alu_a = m_q; alu_b = p_q; end
      4'd7:  begin alu_a = r_q;  alu_b = xp_q; end
      4'd8:  begin alu_a = a_q;  alu_b = b_q; alu_sub = 1'b1; end
      4'd9:  begin alu_a = y_q;  alu_b = s_q; end
      4'd10: begin alu_a = sum_q; alu_b = x_q; end
      4'd11: begin alu_a = sum_q; alu_b = t_q; end
      default: ;
    endcase
  end

  assign mul_r = mul_a * mul_b;
  assign alu_r = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      {x_q, y_q, z_q, p_q, q_q, r_q, s_q, t_q} <= '0;
      {m_q, zp_q, qr_q, xp_q, t4_q, t5_q, a_q, b_q, sum_q} <= '0;
      {o1_q, o2_q, o3_q, o4_q, o5_q, o6_q} <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        x_q <= bus.X; y_q <= bus.Y; z_q <= bus.Z; p_q <= bus.P;
        q_q <= bus.Q; r_q <= bus.R; s_q <= bus.S; t_q <= bus.T;
      end
      if (state_q == COMPUTE) begin
        case (step_q)
          4'd0:  begin m_q <= mul_r; zp_q <= alu_r; end
          4'd1:  qr_q <= alu_r;
          4'd2:  begin o2_q <= mul_r; xp_q <= alu_r; end
          4'd3:  o1_q <= alu_r;
          4'd4:  t4_q <= alu_r;
          4'd5:  begin o4_q <= mul_r; t5_q <= alu_r; end
          4'd6:  begin o6_q <= mul_r; a_q <= alu_r; end
          4'd7:  b_q <= alu_r;
          4'd8:  o5_q <= alu_r;
          4'd9:  sum_q <= alu_r;
          4'd10: sum_q <= alu_r;
          4'd11: o3_q <= alu_r;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == COMPUTE);
  assign bus.step      = (state_q == COMPUTE) ? step_q : 4'd0;
  assign bus.output1   = o1_q;
  assign bus.output2   = o2_q;
  assign bus.output3   = o3_q;
  assign bus.output4   = o4_q;
  assign bus.output5   = o5_q;
  assign bus.output6   = o6_q;

endmodule

// File: tb/tb_expr_shared_scheduler.sv
// Scoreboard bench for expr_shared_scheduler: directed spec vectors plus random operands against a formula model.
module tb_expr_shared_scheduler;

  typedef struct packed {
    logic [31:0] x, y, z, p, q, r, s, t;
  } ops_t;

  typedef struct packed {
    logic [31:0] o1, o2, o3, o4, o5, o6;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } sb_t;

  logic clk;
  logic rst;
  expr_shared_scheduler_if bus();

  expr_shared_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   hs_cnt   = 0;
  int   last_acc = 0;
  int   acc_q[$];
  sb_t  sbq[$];
  res_t pending_exp;
  res_t prev_out;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input ops_t o);
    res_t e;
    e.o1 = o.x * o.y + (o.z + o.p);
    e.o2 = (o.z + o.p) * (o.q - o.r);
    e.o3 = o.y + o.s + o.x + o.t;
    e.o4 = (o.x * o.y + o.q) * (o.x + o.p);
    e.o5 = (o.x * o.y + o.p) - (o.r + (o.x + o.p));
    e.o6 = ((o.x + o.p) + o.y) * (o.q - o.r);
    return e;
  endfunction

  function automatic res_t cur_out();
    res_t c;
    c = {bus.output1, bus.output2, bus.output3, bus.output4, bus.output5, bus.output6};
    return c;
  endfunction

  // Monitor: samples on the falling edge, decides what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_v = 1'b0;
    end else begin
      if (bus.busy) check("step", {28'd0, bus.step}, 32'(cyc - last_acc));
      if (bus.busy || bus.out_valid) check("in_ready_blocked", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          if (!prev_v) check("latency_edges", 32'(cyc + 1 - sbq[0].acc), 32'd13);
          else begin
            check("hold_out1", bus.output1, prev_out.o1);
            check("hold_out6", bus.output6, prev_out.o6);
          end
          if (bus.out_ready) begin
            sb_t e;
            e = sbq.pop_front();
            check("out1", bus.output1, e.r.o1);
            check("out2", bus.output2, e.r.o2);
            check("out3", bus.output3, e.r.o3);
            check("out4", bus.output4, e.r.o4);
            check("out5", bus.output5, e.r.o5);
            check("out6", bus.output6, e.r.o6);
            hs_cnt++;
          end
        end
        prev_v   = !bus.out_ready;
        prev_out = cur_out();
      end else begin
        prev_v = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_t n;
        n.r = pending_exp;
        n.acc = cyc + 1;
        sbq.push_back(n);
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
        acc_cnt++;
      end
    end
  end

  task automatic drive(input ops_t o);
    bus.X = o.x; bus.Y = o.y; bus.Z = o.z; bus.P = o.p;
    bus.Q = o.q; bus.R = o.r; bus.S = o.s; bus.T = o.t;
  endtask

  task automatic wait_accept(input int a0);
    int t = 0;
    while (acc_cnt == a0 && t < 60) begin @(negedge clk); #1; t++; end
    if (acc_cnt == a0) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_cnt < target && t < 80) begin @(negedge clk); #1; t++; end
    if (hs_cnt < target) check("result_timeout", 32'(hs_cnt), 32'(target));
  endtask

  task automatic run(input ops_t o, input res_t e, input int hold);
    int a0 = acc_cnt;
    int h0 = hs_cnt;
    int t = 0;
    @(posedge clk); #1;
    bus.out_ready = (hold == 0);
    pending_exp = e;
    drive(o);
    bus.in_valid = 1'b1;
    wait_accept(a0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      while (!bus.out_valid && t < 40) begin @(negedge clk); #1; t++; end
      repeat (hold) @(negedge clk);
      #1;
      check("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
    end
    wait_hs(h0 + 1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  ops_t nom, wrap, ro;
  res_t nom_exp, wrap_exp;

  initial begin
    int t, a0, h0;
    nom      = '{x:2, y:3, z:4, p:5, q:10, r:7, s:1, t:1};
    nom_exp  = '{o1:32'd15, o2:32'd27, o3:32'd7, o4:32'd112, o5:32'hFFFFFFFD, o6:32'd30};
    wrap     = '{x:32'h00010000, y:32'h00010000, z:32'hFFFFFFFF, p:32'd1, q:0, r:0, s:0, t:0};
    wrap_exp = '{o1:32'd0, o2:32'd0, o3:32'h00020000, o4:32'd0, o5:32'hFFFF0000, o6:32'd0};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    pending_exp = '0;
    drive('0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_step", {28'd0, bus.step}, 32'd0);
    check("rst_out1", bus.output1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run(nom, nom_exp, 0);
    run(wrap, wrap_exp, 0);
    run(nom, nom_exp, 5);
    for (int i = 0; i < 6; i++) begin
      ro = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (i == 0) ro.q = ro.r;
      run(ro, model(ro), $urandom_range(0, 3));
    end

    // Reset in the middle of step 6.
    a0 = acc_cnt;
    @(posedge clk); #1;
    pending_exp = nom_exp;
    drive(nom);
    bus.in_valid = 1'b1;
    wait_accept(a0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 0;
    while (bus.step != 4'd6 && t < 20) begin @(negedge clk); #1; t++; end
    check("reached_step6", {28'd0, bus.step}, 32'd6);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_step", {28'd0, bus.step}, 32'd0);
    check("midrst_outs", bus.output1 | bus.output2 | bus.output3 | bus.output4 | bus.output5 | bus.output6, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(nom, nom_exp, 0);

    // Operand isolation with in_valid held.
    a0 = acc_cnt;
    h0 = hs_cnt;
    @(posedge clk); #1;
    pending_exp = nom_exp;
    drive(nom);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    wait_accept(a0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.X = 32'hDEADBEEF;
    wait_hs(h0 + 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("iso_single_accept", 32'(acc_cnt - a0), 32'd1);

    // Back-to-back accepts.
    a0 = acc_cnt;
    h0 = hs_cnt;
    @(posedge clk); #1;
    pending_exp = nom_exp;
    drive(nom);
    bus.in_valid = 1'b1;
    t = 0;
    while (acc_cnt < a0 + 3 && t < 80) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (acc_cnt < a0 + 3) check("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    else begin
      check("b2b_gap1", 32'(acc_q[a0 + 1] - acc_q[a0]), 32'd14);
      check("b2b_gap2", 32'(acc_q[a0 + 2] - acc_q[a0 + 1]), 32'd14);
    end
    wait_hs(h0 + 3);
    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
